// File: rtl/abus_xarbiter.sv
// abus_xarbiter: multi-master / multi-slave abus arbiter. A registered grant FSM locks one
// master onto one decoded slave window for a whole transaction, returns per-master ack/error,
// and aborts transactions that hang longer than TIMEOUT busy cycles.
module abus_xarbiter #(
    parameter int unsigned                    NB_MASTER  = 2,
    parameter int unsigned                    NB_SLAVE   = 2,
    parameter int unsigned                    ADDR_WIDTH = 16,
    parameter int unsigned                    DATA_WIDTH = 16,
    parameter int unsigned                    SCHEDULER  = 0,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int unsigned                    TIMEOUT    = 16,
    localparam int unsigned                   SW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                            abus_clk,
    input  logic                            abus_rstb,
    input  logic [3*NB_MASTER-1:0]          abus_mid,
    input  logic [NB_MASTER-1:0]            abus_mreq,
    input  logic [NB_MASTER-1:0]            abus_mwrite,
    input  logic [NB_MASTER-1:0]            abus_mread,
    input  logic [NB_MASTER*SW-1:0]         abus_mstrb,
    input  logic [NB_MASTER*SW-1:0]         abus_mkeep,
    input  logic [NB_MASTER*DATA_WIDTH-1:0] abus_mwdata,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0] abus_maddress,
    output logic [NB_MASTER-1:0]            abus_mgrant,
    output logic [NB_MASTER-1:0]            abus_mack,
    output logic [NB_MASTER-1:0]            abus_merr,
    output logic [DATA_WIDTH-1:0]           abus_mrdata,
    input  logic [NB_SLAVE-1:0]             abus_sack,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]  abus_srdata,
    output logic [NB_SLAVE-1:0]             abus_ssel,
    output logic                            abus_sreq,
    output logic                            abus_swrite,
    output logic                            abus_sread,
    output logic                            abus_sabort,
    output logic [2:0]                      abus_smid,
    output logic [SW-1:0]                   abus_sstrb,
    output logic [SW-1:0]                   abus_skeep,
    output logic [ADDR_WIDTH-1:0]           abus_saddress,
    output logic [DATA_WIDTH-1:0]           abus_swdata
);
    localparam int unsigned MW = $clog2(NB_MASTER);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StAbort, StDecerr} state_e;

    state_e                state_q, state_d;
    logic [NB_MASTER-1:0]  grant_q, grant_d;
    logic [NB_SLAVE-1:0]   ssel_q, ssel_d;
    logic [MW-1:0]         gidx_q, gidx_d;
    logic [MW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [MW-1:0]         pick, pick_hi;
    logic                  hi_found;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic                  dec_hit;
    logic [NB_SLAVE-1:0]   dec_sel;
    logic                  g_req, s_ack;
    logic [DATA_WIDTH-1:0] s_rdata;

    // Scheduler: lowest requester overall, overridden in RR mode by lowest at/after pointer.
    always_comb begin
        pick     = '0;
        pick_hi  = '0;
        hi_found = 1'b0;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (abus_mreq[i]) begin
                pick = MW'(i);
                if ((SCHEDULER == 0) && (MW'(i) >= ptr_q)) begin
                    pick_hi  = MW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        if (hi_found) begin
            pick = pick_hi;
        end
    end

    // Address decode of the picked master; descending loop so the lowest matching slave wins.
    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (MW'(i) == pick) begin
                pick_addr = abus_maddress[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int s = NB_SLAVE - 1; s >= 0; s--) begin
            if ((pick_addr & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_hit = 1'b1;
                dec_sel = NB_SLAVE'(1) << s;
            end
        end
    end

    // Granted-master request/data muxes (AND-OR on the one-hot grant, zero when idle).
    always_comb begin
        g_req         = |(abus_mreq & grant_q);
        abus_swrite   = 1'b0;
        abus_sread    = 1'b0;
        abus_smid     = '0;
        abus_sstrb    = '0;
        abus_skeep    = '0;
        abus_saddress = '0;
        abus_swdata   = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (grant_q[i]) begin
                abus_swrite   = abus_swrite | abus_mwrite[i];
                abus_sread    = abus_sread | abus_mread[i];
                abus_smid     = abus_smid | abus_mid[3*i +: 3];
                abus_sstrb    = abus_sstrb | abus_mstrb[i*SW +: SW];
                abus_skeep    = abus_skeep | abus_mkeep[i*SW +: SW];
                abus_saddress = abus_saddress | abus_maddress[i*ADDR_WIDTH +: ADDR_WIDTH];
                abus_swdata   = abus_swdata | abus_mwdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Selected-slave ack/read-data mux; acks from other slaves are ignored.
    always_comb begin
        s_ack   = |(abus_sack & ssel_q);
        s_rdata = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (ssel_q[s]) begin
                s_rdata = s_rdata | abus_srdata[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic and strobe outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ssel_d      = ssel_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        abus_sreq   = 1'b0;
        abus_sabort = 1'b0;
        abus_mack   = '0;
        abus_merr   = '0;
        abus_mrdata = '0;
        unique case (state_q)
            StIdle: begin
                if (|abus_mreq) begin
                    grant_d = NB_MASTER'(1) << pick;
                    gidx_d  = pick;
                    cnt_d   = '0;
                    ssel_d  = dec_sel;
                    state_d = dec_hit ? StBusy : StDecerr;
                end
            end
            StBusy: begin
                abus_sreq = 1'b1;
                if (!g_req) begin
                    // Master abandoned the transaction: tell the slave, no ack back.
                    abus_sreq   = 1'b0;
                    abus_sabort = 1'b1;
                    state_d     = StIdle;
                end else if (s_ack) begin
                    abus_mack   = grant_q;
                    abus_mrdata = s_rdata;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
                        state_d = StAbort;
                    end
                end
            end
            StAbort: begin
                abus_sabort = 1'b1;
                abus_mack   = grant_q;
                abus_merr   = grant_q;
                state_d     = StIdle;
            end
            StDecerr: begin
                abus_mack = grant_q;
                abus_merr = grant_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Every way out of a transaction releases the bus and advances the RR pointer.
        if ((state_q != StIdle) && (state_d == StIdle)) begin
            grant_d = '0;
            ssel_d  = '0;
            cnt_d   = '0;
            ptr_d   = (gidx_q == MW'(NB_MASTER - 1)) ? '0 : gidx_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            state_q <= StIdle;
            grant_q <= '0;
            ssel_q  <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ssel_q  <= ssel_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign abus_mgrant = grant_q;
    assign abus_ssel   = ssel_q;

endmodule

// File: tb/tb_abus_xarbiter.sv
// Randomized bench for abus_xarbiter: a round-robin instance (TIMEOUT 4) and a fixed-priority
// instance (timeout disabled) see the same masters and slaves; a transaction-level model
// predicts every output of both each cycle.
module tb_abus_xarbiter;
    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = $clog2(DW + 1);
    localparam logic [NS*AW-1:0] BASE = {16'h1000, 16'h0000};
    localparam logic [NS*AW-1:0] MASK = {16'hF000, 16'hF000};
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ABORT = 2, PH_DECERR = 3;
    localparam int NCYC = 3000;

    logic abus_clk  = 1'b0;
    logic abus_rstb = 1'b0;
    logic [3*NM-1:0]  mid;
    logic [NM-1:0]    mreq, mwrite, mread;
    logic [NM*SW-1:0] mstrb, mkeep;
    logic [NM*DW-1:0] mwdata;
    logic [NM*AW-1:0] maddr;
    logic [NS-1:0]    sack;
    logic [NS*DW-1:0] srdata;

    logic [NM-1:0] o_mgrant [2];
    logic [NM-1:0] o_mack   [2];
    logic [NM-1:0] o_merr   [2];
    logic [DW-1:0] o_mrdata [2];
    logic [NS-1:0] o_ssel   [2];
    logic          o_sreq   [2];
    logic          o_swrite [2];
    logic          o_sread  [2];
    logic          o_sabort [2];
    logic [2:0]    o_smid   [2];
    logic [SW-1:0] o_sstrb  [2];
    logic [SW-1:0] o_skeep  [2];
    logic [AW-1:0] o_saddr  [2];
    logic [DW-1:0] o_swdata [2];

    abus_xarbiter #(
        .NB_MASTER(NM), .NB_SLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCHEDULER(0),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(4)
    ) dut_rr (
        .abus_clk(abus_clk), .abus_rstb(abus_rstb), .abus_mid(mid), .abus_mreq(mreq),
        .abus_mwrite(mwrite), .abus_mread(mread), .abus_mstrb(mstrb), .abus_mkeep(mkeep),
        .abus_mwdata(mwdata), .abus_maddress(maddr), .abus_mgrant(o_mgrant[0]),
        .abus_mack(o_mack[0]), .abus_merr(o_merr[0]), .abus_mrdata(o_mrdata[0]),
        .abus_sack(sack), .abus_srdata(srdata), .abus_ssel(o_ssel[0]), .abus_sreq(o_sreq[0]),
        .abus_swrite(o_swrite[0]), .abus_sread(o_sread[0]), .abus_sabort(o_sabort[0]),
        .abus_smid(o_smid[0]), .abus_sstrb(o_sstrb[0]), .abus_skeep(o_skeep[0]),
        .abus_saddress(o_saddr[0]), .abus_swdata(o_swdata[0])
    );

    abus_xarbiter #(
        .NB_MASTER(NM), .NB_SLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCHEDULER(1),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(0)
    ) dut_fp (
        .abus_clk(abus_clk), .abus_rstb(abus_rstb), .abus_mid(mid), .abus_mreq(mreq),
        .abus_mwrite(mwrite), .abus_mread(mread), .abus_mstrb(mstrb), .abus_mkeep(mkeep),
        .abus_mwdata(mwdata), .abus_maddress(maddr), .abus_mgrant(o_mgrant[1]),
        .abus_mack(o_mack[1]), .abus_merr(o_merr[1]), .abus_mrdata(o_mrdata[1]),
        .abus_sack(sack), .abus_srdata(srdata), .abus_ssel(o_ssel[1]), .abus_sreq(o_sreq[1]),
        .abus_swrite(o_swrite[1]), .abus_sread(o_sread[1]), .abus_sabort(o_sabort[1]),
        .abus_smid(o_smid[1]), .abus_sstrb(o_sstrb[1]), .abus_skeep(o_skeep[1]),
        .abus_saddress(o_saddr[1]), .abus_swdata(o_swdata[1])
    );

    always #5 abus_clk = ~abus_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: slave windows as the system sees them (slave 0 at 0x0xxx, slave 1 at 0x1xxx).
    logic [AW-1:0] win_base [NS] = '{16'h0000, 16'h1000};
    logic [AW-1:0] win_mask [NS] = '{16'hF000, 16'hF000};
    int tmo_of [2] = '{4, 0};

    int ph [2], own [2], slv [2], waited [2], ptr [2];
    int n_ph [2], n_own [2], n_slv [2], n_waited [2], n_ptr [2];
    logic [31:0] e_grant [2], e_mack [2], e_merr [2], e_mrdata [2], e_ssel [2];
    logic [31:0] e_sreq [2], e_sabort [2], e_swrite [2], e_sread [2], e_smid [2];
    logic [31:0] e_sstrb [2], e_skeep [2], e_saddr [2], e_swdata [2];
    logic [NM-1:0] req_live;

    function automatic int decode(input logic [AW-1:0] a);
        for (int s = 0; s < NS; s++) begin
            if ((a & win_mask[s]) == win_base[s]) return s;
        end
        return -1;
    endfunction

    function automatic int pick_master(input int k);
        for (int j = 0; j < NM; j++) begin
            int m;
            m = (k == 1) ? j : (ptr[k] + j) % NM;
            if (mreq[m]) return m;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = PH_IDLE; own[k] = 0; slv[k] = -1; waited[k] = 0; ptr[k] = 0;
        end
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            ph[k] = n_ph[k]; own[k] = n_own[k]; slv[k] = n_slv[k];
            waited[k] = n_waited[k]; ptr[k] = n_ptr[k];
        end
    endtask

    task automatic finish_txn(input int k);
        n_ph[k]  = PH_IDLE;
        n_ptr[k] = (own[k] + 1) % NM;
    endtask

    // Expected outputs for the current inputs, plus what the next clock edge will do.
    task automatic model_eval(input int k);
        int g, o;
        n_ph[k] = ph[k]; n_own[k] = own[k]; n_slv[k] = slv[k];
        n_waited[k] = waited[k]; n_ptr[k] = ptr[k];
        e_grant[k] = 0; e_mack[k] = 0; e_merr[k] = 0; e_mrdata[k] = 0; e_ssel[k] = 0;
        e_sreq[k] = 0; e_sabort[k] = 0; e_swrite[k] = 0; e_sread[k] = 0; e_smid[k] = 0;
        e_sstrb[k] = 0; e_skeep[k] = 0; e_saddr[k] = 0; e_swdata[k] = 0;
        o = own[k];
        if (ph[k] != PH_IDLE) begin
            e_grant[k]  = 32'(1) << o;
            e_swrite[k] = 32'(mwrite[o]);
            e_sread[k]  = 32'(mread[o]);
            e_smid[k]   = 32'(mid[o*3 +: 3]);
            e_sstrb[k]  = 32'(mstrb[o*SW +: SW]);
            e_skeep[k]  = 32'(mkeep[o*SW +: SW]);
            e_saddr[k]  = 32'(maddr[o*AW +: AW]);
            e_swdata[k] = 32'(mwdata[o*DW +: DW]);
        end
        case (ph[k])
            PH_IDLE: begin
                g = pick_master(k);
                if (g >= 0) begin
                    n_own[k]    = g;
                    n_slv[k]    = decode(maddr[g*AW +: AW]);
                    n_waited[k] = 0;
                    n_ph[k]     = (n_slv[k] >= 0) ? PH_WAIT : PH_DECERR;
                end
            end
            PH_WAIT: begin
                e_ssel[k] = 32'(1) << slv[k];
                e_sreq[k] = 1;
                if (!mreq[o]) begin
                    e_sreq[k]   = 0;
                    e_sabort[k] = 1;
                    finish_txn(k);
                end else if (sack[slv[k]]) begin
                    e_mack[k]   = 32'(1) << o;
                    e_mrdata[k] = 32'(srdata[slv[k]*DW +: DW]);
                    finish_txn(k);
                end else begin
                    n_waited[k] = waited[k] + 1;
                    if (tmo_of[k] != 0 && n_waited[k] == tmo_of[k]) n_ph[k] = PH_ABORT;
                end
            end
            PH_ABORT: begin
                e_ssel[k]   = 32'(1) << slv[k];
                e_sabort[k] = 1;
                e_mack[k]   = 32'(1) << o;
                e_merr[k]   = 32'(1) << o;
                finish_txn(k);
            end
            default: begin
                e_mack[k] = 32'(1) << o;
                e_merr[k] = 32'(1) << o;
                finish_txn(k);
            end
        endcase
    endtask

    task automatic compare_dut(input int k, input int cyc);
        string p;
        p = $sformatf("%s c%0d", (k == 0) ? "rr" : "fp", cyc);
        check_eq({p, " mgrant"}, 32'(o_mgrant[k]), e_grant[k]);
        check_eq({p, " mack"}, 32'(o_mack[k]), e_mack[k]);
        check_eq({p, " merr"}, 32'(o_merr[k]), e_merr[k]);
        check_eq({p, " mrdata"}, 32'(o_mrdata[k]), e_mrdata[k]);
        check_eq({p, " ssel"}, 32'(o_ssel[k]), e_ssel[k]);
        check_eq({p, " sreq"}, 32'(o_sreq[k]), e_sreq[k]);
        check_eq({p, " sabort"}, 32'(o_sabort[k]), e_sabort[k]);
        check_eq({p, " swrite"}, 32'(o_swrite[k]), e_swrite[k]);
        check_eq({p, " sread"}, 32'(o_sread[k]), e_sread[k]);
        check_eq({p, " smid"}, 32'(o_smid[k]), e_smid[k]);
        check_eq({p, " sstrb"}, 32'(o_sstrb[k]), e_sstrb[k]);
        check_eq({p, " skeep"}, 32'(o_skeep[k]), e_skeep[k]);
        check_eq({p, " saddress"}, 32'(o_saddr[k]), e_saddr[k]);
        check_eq({p, " swdata"}, 32'(o_swdata[k]), e_swdata[k]);
    endtask

    task automatic check_zero(input int k, input string p);
        check_eq({p, " mgrant"}, 32'(o_mgrant[k]), 0);
        check_eq({p, " mack"}, 32'(o_mack[k]), 0);
        check_eq({p, " merr"}, 32'(o_merr[k]), 0);
        check_eq({p, " mrdata"}, 32'(o_mrdata[k]), 0);
        check_eq({p, " ssel"}, 32'(o_ssel[k]), 0);
        check_eq({p, " sreq"}, 32'(o_sreq[k]), 0);
        check_eq({p, " sabort"}, 32'(o_sabort[k]), 0);
        check_eq({p, " smid"}, 32'(o_smid[k]), 0);
        check_eq({p, " saddress"}, 32'(o_saddr[k]), 0);
        check_eq({p, " swdata"}, 32'(o_swdata[k]), 0);
    endtask

    task automatic new_request(input int m);
        int r;
        logic [3:0] nib;
        r = $urandom_range(4);
        nib = (r < 2) ? 4'h0 : (r < 4) ? 4'h1 : 4'(8 + $urandom_range(7));
        req_live[m]          = 1'b1;
        mreq[m]              = 1'b1;
        maddr[m*AW +: AW]    = {nib, 12'($urandom)};
        mwrite[m]            = 1'($urandom);
        mread[m]             = ~mwrite[m];
        mid[m*3 +: 3]        = 3'($urandom);
        mstrb[m*SW +: SW]    = SW'($urandom);
        mkeep[m*SW +: SW]    = SW'($urandom);
        mwdata[m*DW +: DW]   = DW'($urandom);
    endtask

    // Masters follow the round-robin instance's completions; occasionally one gives up.
    task automatic drive_masters();
        for (int m = 0; m < NM; m++) begin
            if (req_live[m] && e_mack[0][m]) begin
                req_live[m] = 1'b0;
                mreq[m]     = 1'b0;
            end else if (req_live[m] && $urandom_range(63) == 0) begin
                req_live[m] = 1'b0;
                mreq[m]     = 1'b0;
            end else if (!req_live[m] && $urandom_range(1) == 0) begin
                new_request(m);
            end
        end
        for (int s = 0; s < NS; s++) sack[s] = ($urandom_range(2) == 0);
        srdata = {16'($urandom), 16'($urandom)};
    endtask

    initial begin
        bit pending;
        bit did_rst;
        mid = '0; mreq = '0; mwrite = '0; mread = '0; mstrb = '0; mkeep = '0;
        mwdata = '0; maddr = '0; sack = '0; srdata = '0; req_live = '0;
        pending = 1'b0;
        did_rst = 1'b0;
        model_reset();
        #3;
        check_zero(0, "rr reset");
        check_zero(1, "fp reset");
        @(negedge abus_clk);
        abus_rstb = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge abus_clk);
            #1;
            if (pending) model_commit();
            if (!did_rst && cyc >= NCYC / 2 && ph[0] == PH_WAIT) begin
                // Reset in the middle of a busy transaction, then both masters request.
                did_rst   = 1'b1;
                abus_rstb = 1'b0;
                #1;
                check_zero(0, $sformatf("rr c%0d midreset", cyc));
                check_zero(1, $sformatf("fp c%0d midreset", cyc));
                model_reset();
                new_request(0);
                new_request(1);
                sack = '0;
                @(negedge abus_clk);
                for (int k = 0; k < 2; k++) begin
                    model_eval(k);
                    compare_dut(k, cyc);
                end
                abus_rstb = 1'b1;
                pending   = 1'b1;
                continue;
            end
            drive_masters();
            @(negedge abus_clk);
            for (int k = 0; k < 2; k++) begin
                model_eval(k);
                compare_dut(k, cyc);
            end
            pending = 1'b1;
        end
        check_eq("midreset exercised", 32'(did_rst), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
